// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin between two writeback requesters,
// plus a sequencer that zeroes x1..x31 on command. WE3/WA3/WD3 are registered.
module rf_write_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          WE3,
    output logic [AW-1:0] WA3,
    output logic [DW-1:0] WD3
);

    // state | meaning
    // IDLE  | arbitrating requesters, clr_start accepted
    // CLEAR | presenting zero writes to x2..x31, requesters stalled
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_TWO  = AW'(2);
    localparam logic [AW-1:0] ADDR_LAST = '1;

    state_t        r_state, w_state_nxt;
    logic          r_rr_ptr, w_rr_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;
    logic          r_we, w_we_nxt;
    logic [AW-1:0] r_wa, w_wa_nxt;
    logic [DW-1:0] r_wd, w_wd_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          w_grant0, w_grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_we     <= w_we_nxt;
            r_wa     <= w_wa_nxt;
            r_wd     <= w_wd_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = 1'b0;
        w_wa_nxt    = r_wa;
        w_wd_nxt    = r_wd;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_we_nxt    = 1'b1;
                    w_wa_nxt    = ADDR_ONE;
                    w_wd_nxt    = '0;
                    w_cnt_nxt   = ADDR_TWO;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_grant0 = req0_valid && (!req1_valid || !r_rr_ptr);
                    w_grant1 = req1_valid && (!req0_valid ||  r_rr_ptr);
                    if (w_grant0) begin
                        w_rr_nxt = 1'b1;
                        if (req0_addr != '0) begin
                            w_we_nxt = 1'b1;
                            w_wa_nxt = req0_addr;
                            w_wd_nxt = req0_data;
                        end
                    end else if (w_grant1) begin
                        w_rr_nxt = 1'b0;
                        if (req1_addr != '0) begin
                            w_we_nxt = 1'b1;
                            w_wa_nxt = req1_addr;
                            w_wd_nxt = req1_data;
                        end
                    end
                end
            end
            S_CLEAR: begin
                w_we_nxt   = 1'b1;
                w_wa_nxt   = r_cnt;
                w_wd_nxt   = '0;
                w_busy_nxt = 1'b1;
                // Loading the top address ends the sweep; done lines up with it.
                if (r_cnt == ADDR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign WE3        = r_we;
    assign WA3        = r_wa;
    assign WD3        = r_wd;
    assign clr_busy   = r_busy;
    assign clr_done   = r_done;

endmodule
